z80_bus_arbiter: RTL and testbench
==================================

# z80_bus_arbiter

Shares the TV80 system bus between the Z80 core and up to N DMA requesters. It drives the core's active-high BUSRQ and waits for BUSAK. It then grants the bus round-robin to one requester at a time and enforces a per-tenure hold limit. After each tenure it guarantees the CPU a minimum run window before the next request. Its outputs steer the address, data and strobe multiplexers that sit between the core and the memory/IO fabric.

## Interface
- N_REQ, 4, number of DMA requesters (1..8)
- MAX_HOLD, 64, cycles of DMA tenure after which YIELD is raised and the bus returns to the CPU at the next release (1..255)
- CPU_MIN, 8, cycles the CPU owns the bus after BUSAK falls before BUSRQ may rise again (0..255)

- CLK  in  1  system clock; all logic on rising edge
- nRESET  in  1  synchronous, active-low reset
- BUSAK  in  1  active-high bus acknowledge from the core
- REQ  in  N_REQ  per-requester bus request, level; held until the transfer is complete
- BUSRQ  out  1  active-high bus request to the core, registered
- GNT  out  N_REQ  one-hot grant, registered; never more than one bit set
- OWNER  out  max(1,$clog2(N_REQ))  index of the current or last grantee
- BUS_DMA  out  1  high when any GNT bit is set; select for the bus multiplexers
- YIELD  out  1  high to the current grantee once its tenure reaches MAX_HOLD
- ABORT  out  1  one-cycle pulse when BUSAK is lost during a grant

## Operation
- States are IDLE, ACQ, GRANT, GAP, REL and COOL.
- IDLE: BUSRQ=0. If any REQ is set and the cooldown counter is 0, go to ACQ and set BUSRQ=1.
- ACQ: BUSRQ=1; wait for BUSAK=1.
  - On BUSAK with REQ≠0, pick the winner: the first set REQ bit scanning from OWNER+1 upward, wrapping modulo N_REQ.
  - Set GNT[winner]=1, set OWNER=winner, clear the hold counter, and go to GRANT.
  - On BUSAK with REQ=0 (all requesters withdrew), go to REL.
- GRANT: the hold counter increments each cycle and saturates at MAX_HOLD. YIELD=1 while counter==MAX_HOLD.
  - When REQ[OWNER] falls, clear GNT.
  - If the counter is below MAX_HOLD and another REQ bit is set, go to GAP.
  - Otherwise go to REL.
- GAP: one dead cycle with GNT=0 and BUSRQ still 1. Then arbitrate exactly as in ACQ using the current REQ, with no BUSAK wait. The hold counter is not cleared, because the limit applies to the whole BUSRQ tenure.
- REL: BUSRQ=0; wait for BUSAK=0. Then load the cooldown counter with CPU_MIN and go to COOL, or go straight to IDLE if CPU_MIN=0.
- COOL: decrement each cycle; go to IDLE when it reaches 0.
- BUSAK falling while GNT≠0 (core reset or glitch):
  - clear GNT and YIELD the same edge;
  - pulse ABORT;
  - BUSRQ=0;
  - go to REL, which completes immediately since BUSAK is already low.
- REQ bits rising during REL or COOL are held off until IDLE.
- A grantee dropping REQ in ACQ before it is granted is simply not selected.

## Timing
- Reset values, applied on the first edge with nRESET=0:
  - BUSRQ, GNT, BUS_DMA, YIELD and ABORT = 0;
  - OWNER = N_REQ-1, so requester 0 wins first;
  - counters = 0; state = IDLE.
- Reset mid-grant drops GNT and BUSRQ on that same edge.
- REQ sampled high at edge k in IDLE → BUSRQ=1 after edge k.
- BUSAK sampled high at edge k in ACQ → GNT and BUS_DMA high after edge k.
- REQ[OWNER] sampled low at edge k → GNT low after edge k.
  - If the next grant follows, it is high after edge k+1.
  - Otherwise BUSRQ is low after edge k.
- YIELD rises after the edge on which the counter reaches MAX_HOLD, and falls with GNT.
- BUSAK low sampled at edge k in REL → COOL lasts CPU_MIN cycles, so BUSRQ can rise again no earlier than after edge k+CPU_MIN+1.
- GNT, BUS_DMA and OWNER change only on edges. BUS_DMA equals OR(GNT) at all times.

## Test plan
- REQ=0001 held 10 cycles; core acks 3 cycles after BUSRQ → GNT=0001 one cycle after BUSAK, OWNER=0, BUSRQ low one cycle after REQ drops, next BUSRQ no earlier than CPU_MIN+1 cycles after BUSAK falls.
- REQ=0101 from IDLE, each requester holds 5 cycles → GNT order 0001, gap, 0100, then REL. Repeat with REQ=0101 → order 0001 then 0100 again (OWNER wrapped from 2 to 0).
- MAX_HOLD=16, REQ=0011, requester 0 holds 20 cycles → YIELD high after 16 cycles of tenure; after release BUSRQ falls and requester 1 waits for the next ACQ after cooldown.
- REQ=0010 raised then dropped before BUSAK → no GNT ever set, BUSRQ falls after BUSAK rises, cooldown observed.
- BUSAK forced low during GRANT → GNT=0 and ABORT=1 for exactly one cycle, BUSRQ=0, re-arbitration after CPU_MIN cycles if REQ remains set.
- nRESET=0 for one cycle mid-GRANT → all outputs 0 after that edge, OWNER=N_REQ-1, and the next grant goes to requester 0 when multiple REQ bits are set.

Source files
------------

// File: rtl/z80_bus_arbiter_if.sv
// Bus-side signals of the TV80 DMA arbiter: core handshake plus per-requester request/grant.
// master = arbiter, slave = core/requester side.
interface z80_bus_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic             BUSAK;
  logic [N_REQ-1:0] REQ;
  logic             BUSRQ;
  logic [N_REQ-1:0] GNT;
  logic [OW-1:0]    OWNER;
  logic             BUS_DMA;
  logic             YIELD;
  logic             ABORT;

  modport master (
    input  BUSAK, REQ,
    output BUSRQ, GNT, OWNER, BUS_DMA, YIELD, ABORT
  );

  modport slave (
    output BUSAK, REQ,
    input  BUSRQ, GNT, OWNER, BUS_DMA, YIELD, ABORT
  );
endinterface

// File: rtl/z80_bus_arbiter.sv
// Shares the TV80 bus between the Z80 core and N_REQ DMA requesters: BUSRQ/BUSAK handshake,
// round-robin grants, per-tenure hold limit and a guaranteed CPU run window between tenures.
module z80_bus_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned CPU_MIN  = 8
) (
  input  logic                CLK,
  input  logic                nRESET,
  z80_bus_arbiter_if.master   bus
);
  localparam int unsigned OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  HOLD_MAX = 8'(MAX_HOLD);
  localparam logic [7:0]  COOL_LD  = 8'(CPU_MIN);

  typedef enum logic [2:0] {IDLE, ACQ, GRANT, GAP, REL, COOL} state_t;

  state_t           state, state_n;
  logic [7:0]       hold, hold_n, cool, cool_n;
  logic [N_REQ-1:0] gnt, gnt_n;
  logic [OW-1:0]    owner, owner_n;
  logic             busrq, busrq_n, yield, yield_n, abort, abort_n;

  logic             any_req, own_req, other_req;
  logic             found_hi;
  logic [OW-1:0]    win_hi, win_lo, win;

  // GNT is one-hot on OWNER while granted, so masking REQ with it avoids a variable index
  assign any_req   = |bus.REQ;
  assign own_req   = |(bus.REQ & gnt);
  assign other_req = |(bus.REQ & ~gnt);

  // Round-robin: first set bit above OWNER, otherwise first set bit from 0 (wrap)
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned j = N_REQ; j > 0; j--) begin
      if (bus.REQ[j-1]) begin
        win_lo = OW'(j-1);
        if ((j-1) > 32'(owner)) begin
          found_hi = 1'b1;
          win_hi   = OW'(j-1);
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state <= IDLE;
      hold  <= '0;
      cool  <= '0;
      gnt   <= '0;
      owner <= OW'(N_REQ - 1);
      busrq <= 1'b0;
      yield <= 1'b0;
      abort <= 1'b0;
    end else begin
      state <= state_n;
      hold  <= hold_n;
      cool  <= cool_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      busrq <= busrq_n;
      yield <= yield_n;
      abort <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold;
    cool_n  = cool;
    case (state)
      IDLE:  if (any_req && cool == '0) state_n = ACQ;
      ACQ:   if (bus.BUSAK) begin
               hold_n  = '0;
               state_n = any_req ? GRANT : REL;
             end
      GRANT: if (!bus.BUSAK)  state_n = REL;
             else if (!own_req) state_n = (hold < HOLD_MAX && other_req) ? GAP : REL;
             else if (hold != HOLD_MAX) hold_n = hold + 8'd1;
      // Hold counter deliberately carried across the gap: the limit covers the whole BUSRQ tenure
      GAP:   if (!bus.BUSAK) state_n = REL;
             else            state_n = any_req ? GRANT : REL;
      REL:   if (!bus.BUSAK) begin
               if (COOL_LD == '0) state_n = IDLE;
               else begin
                 cool_n  = COOL_LD;
                 state_n = COOL;
               end
             end
      COOL:  begin
               cool_n = (cool == '0) ? '0 : cool - 8'd1;
               if (cool <= 8'd1) state_n = IDLE;
             end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt_n   = gnt;
    owner_n = owner;
    busrq_n = (state_n == ACQ) || (state_n == GRANT) || (state_n == GAP);
    abort_n = (state == GRANT) && !bus.BUSAK;
    if ((state == ACQ || state == GAP) && state_n == GRANT) begin
      gnt_n   = N_REQ'(1) << win;
      owner_n = win;
    end
    if (state_n != GRANT) gnt_n = '0;
    yield_n = (state_n == GRANT) && (hold_n == HOLD_MAX);
  end

  assign bus.BUSRQ   = busrq;
  assign bus.GNT     = gnt;
  assign bus.OWNER   = owner;
  assign bus.BUS_DMA = |gnt;
  assign bus.YIELD   = yield;
  assign bus.ABORT   = abort;
endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter (N_REQ=4, MAX_HOLD=16, CPU_MIN=8); the bench plays the core
// and the requesters by hand, all changes and samples 1 time unit after the rising edge.
module tb_z80_bus_arbiter;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  z80_bus_arbiter_if #(.N_REQ(4)) bus ();

  z80_bus_arbiter #(.N_REQ(4), .MAX_HOLD(16), .CPU_MIN(8)) dut (
    .CLK(clk),
    .nRESET(nreset),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    bus.REQ = 4'b0000;
    bus.BUSAK = 1'b0;
    tick();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    bus.REQ = 4'b0101;
    bus.BUSAK = 1'b1;
    nreset = 1'b0;
    tick();
    vectors++; if (bus.BUSRQ !== 1'b0) begin miscompares++; $display("FAIL reset_busrq: got %b expected 0", bus.BUSRQ); end
    vectors++; if (bus.GNT !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", bus.GNT); end
    vectors++; if (bus.BUS_DMA !== 1'b0) begin miscompares++; $display("FAIL reset_bus_dma: got %b expected 0", bus.BUS_DMA); end
    vectors++; if ({bus.YIELD, bus.ABORT} !== 2'b00) begin miscompares++; $display("FAIL reset_yield_abort: got %b expected 00", {bus.YIELD, bus.ABORT}); end
    vectors++; if (bus.OWNER !== 2'd3) begin miscompares++; $display("FAIL reset_owner: got %0d expected 3", bus.OWNER); end
    do_reset();
  endtask

  task automatic test_single();
    logic seen;
    do_reset();
    bus.REQ = 4'b0001;
    tick();
    vectors++; if ({bus.BUSRQ, bus.GNT} !== 5'b1_0000) begin miscompares++; $display("FAIL single_busrq: got busrq=%b gnt=%b expected 1 0000", bus.BUSRQ, bus.GNT); end
    tick(); tick();
    vectors++; if (bus.GNT !== 4'b0000) begin miscompares++; $display("FAIL single_wait_ack: got %b expected 0000", bus.GNT); end
    bus.BUSAK = 1'b1;
    tick();
    vectors++; if ({bus.GNT, bus.BUS_DMA} !== 5'b0001_1) begin miscompares++; $display("FAIL single_gnt: got gnt=%b dma=%b expected 0001 1", bus.GNT, bus.BUS_DMA); end
    vectors++; if (bus.OWNER !== 2'd0) begin miscompares++; $display("FAIL single_owner: got %0d expected 0", bus.OWNER); end
    repeat (6) tick();
    vectors++; if ({bus.GNT, bus.YIELD} !== 5'b0001_0) begin miscompares++; $display("FAIL single_hold: got gnt=%b yield=%b expected 0001 0", bus.GNT, bus.YIELD); end
    bus.REQ = 4'b0000;
    tick();
    vectors++; if ({bus.GNT, bus.BUS_DMA, bus.BUSRQ} !== 6'b0000_0_0) begin miscompares++; $display("FAIL single_release: got gnt=%b dma=%b busrq=%b expected 0000 0 0", bus.GNT, bus.BUS_DMA, bus.BUSRQ); end
    bus.BUSAK = 1'b0;
    bus.REQ = 4'b0001;
    tick();
    seen = bus.BUSRQ;
    repeat (8) begin tick(); seen |= bus.BUSRQ; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL single_cooldown: got busrq seen=%b expected 0", seen); end
    tick();
    vectors++; if (bus.BUSRQ !== 1'b1) begin miscompares++; $display("FAIL single_rerequest: got %b expected 1", bus.BUSRQ); end
  endtask

  task automatic test_round_robin();
    logic seen;
    do_reset();
    bus.REQ = 4'b0101;
    tick();
    bus.BUSAK = 1'b1;
    tick();
    vectors++; if ({bus.GNT, bus.OWNER} !== 6'b0001_00) begin miscompares++; $display("FAIL rr_first: got gnt=%b owner=%0d expected 0001 0", bus.GNT, bus.OWNER); end
    repeat (4) tick();
    bus.REQ = 4'b0100;
    tick();
    vectors++; if ({bus.GNT, bus.BUSRQ} !== 5'b0000_1) begin miscompares++; $display("FAIL rr_gap: got gnt=%b busrq=%b expected 0000 1", bus.GNT, bus.BUSRQ); end
    tick();
    vectors++; if ({bus.GNT, bus.OWNER, bus.BUS_DMA} !== 7'b0100_10_1) begin miscompares++; $display("FAIL rr_second: got gnt=%b owner=%0d dma=%b expected 0100 2 1", bus.GNT, bus.OWNER, bus.BUS_DMA); end
    repeat (4) tick();
    bus.REQ = 4'b0000;
    tick();
    vectors++; if ({bus.GNT, bus.BUSRQ} !== 5'b0000_0) begin miscompares++; $display("FAIL rr_release: got gnt=%b busrq=%b expected 0000 0", bus.GNT, bus.BUSRQ); end
    bus.BUSAK = 1'b0;
    bus.REQ = 4'b0101;
    seen = 1'b0;
    repeat (9) begin tick(); seen |= bus.BUSRQ; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rr_cooldown: got busrq seen=%b expected 0", seen); end
    tick();
    vectors++; if (bus.BUSRQ !== 1'b1) begin miscompares++; $display("FAIL rr_rerequest: got %b expected 1", bus.BUSRQ); end
    bus.BUSAK = 1'b1;
    tick();
    vectors++; if ({bus.GNT, bus.OWNER} !== 6'b0001_00) begin miscompares++; $display("FAIL rr_wrap_first: got gnt=%b owner=%0d expected 0001 0", bus.GNT, bus.OWNER); end
    bus.REQ = 4'b0100;
    tick();
    tick();
    vectors++; if ({bus.GNT, bus.OWNER} !== 6'b0100_10) begin miscompares++; $display("FAIL rr_wrap_second: got gnt=%b owner=%0d expected 0100 2", bus.GNT, bus.OWNER); end
  endtask

  task automatic test_yield();
    logic seen;
    do_reset();
    bus.REQ = 4'b0011;
    tick();
    bus.BUSAK = 1'b1;
    tick();
    vectors++; if ({bus.GNT, bus.YIELD} !== 5'b0001_0) begin miscompares++; $display("FAIL yield_grant: got gnt=%b yield=%b expected 0001 0", bus.GNT, bus.YIELD); end
    repeat (15) tick();
    vectors++; if (bus.YIELD !== 1'b0) begin miscompares++; $display("FAIL yield_early: got %b expected 0", bus.YIELD); end
    tick();
    vectors++; if (bus.YIELD !== 1'b1) begin miscompares++; $display("FAIL yield_rise: got %b expected 1", bus.YIELD); end
    repeat (4) tick();
    vectors++; if ({bus.GNT, bus.YIELD} !== 5'b0001_1) begin miscompares++; $display("FAIL yield_hold: got gnt=%b yield=%b expected 0001 1", bus.GNT, bus.YIELD); end
    bus.REQ = 4'b0010;
    tick();
    vectors++; if ({bus.GNT, bus.YIELD, bus.BUSRQ} !== 6'b0000_0_0) begin miscompares++; $display("FAIL yield_release: got gnt=%b yield=%b busrq=%b expected 0000 0 0", bus.GNT, bus.YIELD, bus.BUSRQ); end
    bus.BUSAK = 1'b0;
    seen = 1'b0;
    repeat (9) begin tick(); seen |= bus.BUSRQ; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL yield_cooldown: got busrq seen=%b expected 0", seen); end
    tick();
    vectors++; if (bus.BUSRQ !== 1'b1) begin miscompares++; $display("FAIL yield_rerequest: got %b expected 1", bus.BUSRQ); end
    bus.BUSAK = 1'b1;
    tick();
    vectors++; if ({bus.GNT, bus.OWNER, bus.YIELD} !== 7'b0010_01_0) begin miscompares++; $display("FAIL yield_next_owner: got gnt=%b owner=%0d yield=%b expected 0010 1 0", bus.GNT, bus.OWNER, bus.YIELD); end
  endtask

  task automatic test_withdraw();
    logic seen;
    do_reset();
    bus.REQ = 4'b0010;
    tick();
    bus.REQ = 4'b0000;
    tick();
    vectors++; if ({bus.BUSRQ, bus.GNT} !== 5'b1_0000) begin miscompares++; $display("FAIL withdraw_acq: got busrq=%b gnt=%b expected 1 0000", bus.BUSRQ, bus.GNT); end
    bus.BUSAK = 1'b1;
    tick();
    vectors++; if ({bus.BUSRQ, bus.GNT} !== 5'b0_0000) begin miscompares++; $display("FAIL withdraw_rel: got busrq=%b gnt=%b expected 0 0000", bus.BUSRQ, bus.GNT); end
    bus.BUSAK = 1'b0;
    bus.REQ = 4'b0010;
    seen = 1'b0;
    repeat (9) begin tick(); seen |= bus.BUSRQ | bus.BUS_DMA; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL withdraw_cooldown: got busrq/dma seen=%b expected 0", seen); end
    tick();
    vectors++; if ({bus.BUSRQ, bus.OWNER} !== 3'b1_11) begin miscompares++; $display("FAIL withdraw_rerequest: got busrq=%b owner=%0d expected 1 3", bus.BUSRQ, bus.OWNER); end
  endtask

  task automatic test_abort();
    logic seen;
    do_reset();
    bus.REQ = 4'b0100;
    tick();
    bus.BUSAK = 1'b1;
    tick();
    vectors++; if ({bus.GNT, bus.OWNER} !== 6'b0100_10) begin miscompares++; $display("FAIL abort_grant: got gnt=%b owner=%0d expected 0100 2", bus.GNT, bus.OWNER); end
    tick();
    bus.BUSAK = 1'b0;
    tick();
    vectors++; if ({bus.GNT, bus.BUS_DMA, bus.ABORT, bus.BUSRQ, bus.YIELD} !== 8'b0000_0_1_0_0) begin miscompares++; $display("FAIL abort_hit: got gnt=%b dma=%b abort=%b busrq=%b yield=%b expected 0000 0 1 0 0", bus.GNT, bus.BUS_DMA, bus.ABORT, bus.BUSRQ, bus.YIELD); end
    tick();
    vectors++; if ({bus.ABORT, bus.BUSRQ} !== 2'b00) begin miscompares++; $display("FAIL abort_pulse: got abort=%b busrq=%b expected 0 0", bus.ABORT, bus.BUSRQ); end
    seen = 1'b0;
    repeat (8) begin tick(); seen |= bus.BUSRQ | bus.ABORT; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_cooldown: got busrq/abort seen=%b expected 0", seen); end
    tick();
    vectors++; if (bus.BUSRQ !== 1'b1) begin miscompares++; $display("FAIL abort_rerequest: got %b expected 1", bus.BUSRQ); end
    bus.BUSAK = 1'b1;
    tick();
    vectors++; if ({bus.GNT, bus.OWNER} !== 6'b0100_10) begin miscompares++; $display("FAIL abort_regrant: got gnt=%b owner=%0d expected 0100 2", bus.GNT, bus.OWNER); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.REQ = 4'b0010;
    tick();
    bus.BUSAK = 1'b1;
    tick();
    vectors++; if ({bus.GNT, bus.OWNER} !== 6'b0010_01) begin miscompares++; $display("FAIL rstmid_grant: got gnt=%b owner=%0d expected 0010 1", bus.GNT, bus.OWNER); end
    tick();
    nreset = 1'b0;
    bus.REQ = 4'b0011;
    tick();
    vectors++; if ({bus.BUSRQ, bus.GNT, bus.BUS_DMA, bus.YIELD, bus.ABORT} !== 8'b0_0000_000) begin miscompares++; $display("FAIL rstmid_outputs: got busrq=%b gnt=%b dma=%b yield=%b abort=%b expected all 0", bus.BUSRQ, bus.GNT, bus.BUS_DMA, bus.YIELD, bus.ABORT); end
    vectors++; if (bus.OWNER !== 2'd3) begin miscompares++; $display("FAIL rstmid_owner: got %0d expected 3", bus.OWNER); end
    nreset = 1'b1;
    bus.BUSAK = 1'b0;
    tick();
    vectors++; if (bus.BUSRQ !== 1'b1) begin miscompares++; $display("FAIL rstmid_busrq: got %b expected 1", bus.BUSRQ); end
    bus.BUSAK = 1'b1;
    tick();
    vectors++; if ({bus.GNT, bus.OWNER} !== 6'b0001_00) begin miscompares++; $display("FAIL rstmid_regrant: got gnt=%b owner=%0d expected 0001 0", bus.GNT, bus.OWNER); end
  endtask

  initial begin
    bus.REQ = 4'b0000;
    bus.BUSAK = 1'b0;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_yield();
    test_withdraw();
    test_abort();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
